// File: rtl/store_buffer_pkg.sv
// Shared widths and the entry payload type for the posted-write store buffer.
package store_buffer_pkg;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned ADDR_W = 9;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [PTR_W-1:0]  ptr_t;
    typedef logic [CNT_W-1:0]  cnt_t;

    typedef struct packed {
        addr_t addr;
        data_t data;
    } sb_entry_t;

endpackage

// File: rtl/store_buffer_if.sv
// Pipeline-side and DataMemory-side signals of the store buffer.
interface store_buffer_if;
    import store_buffer_pkg::*;

    logic  mem_write;
    logic  mem_read;
    addr_t address;
    data_t write_data;
    data_t load_data;
    logic  stall;
    logic  empty;
    addr_t dm_address;
    data_t dm_write_data;
    logic  dm_write;
    logic  dm_read;
    data_t dm_read_data;

    modport slave (
        input  mem_write, mem_read, address, write_data, dm_read_data,
        output load_data, stall, empty, dm_address, dm_write_data, dm_write, dm_read
    );

    modport master (
        output mem_write, mem_read, address, write_data, dm_read_data,
        input  load_data, stall, empty, dm_address, dm_write_data, dm_write, dm_read
    );

endinterface

// File: rtl/store_buffer_sb_fwd_match.sv
// Finds the youngest valid entry whose address matches a load address.
module store_buffer_sb_fwd_match
    import store_buffer_pkg::*;
(
    input  logic [DEPTH-1:0]  valid,
    input  addr_t [DEPTH-1:0] entry_addr,
    input  ptr_t              head,
    input  addr_t             lookup,
    output logic              hit,
    output ptr_t              idx
);

    // Walk oldest to youngest from head so the last match wins.
    always_comb begin
        ptr_t slot;
        hit  = 1'b0;
        idx  = head;
        slot = head;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            slot = head + PTR_W'(k);
            if (valid[slot] && (entry_addr[slot] == lookup)) begin
                hit = 1'b1;
                idx = slot;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer: stores enqueue without using the memory port and drain
// in FIFO order on idle port cycles; loads forward from the youngest match.
module store_buffer
    import store_buffer_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    store_buffer_if.slave bus
);

    sb_entry_t         entries [DEPTH];
    ptr_t              head;
    ptr_t              tail;
    cnt_t              count;
    logic              full;
    logic              enq;
    logic              drain;
    logic              hit;
    ptr_t              hit_idx;
    logic [DEPTH-1:0]  valid;
    addr_t [DEPTH-1:0] entry_addr;

    assign full  = (count == CNT_W'(DEPTH));
    assign enq   = bus.mem_write && !bus.mem_read && !full;
    assign drain = !bus.mem_read && !enq && (count != '0);

    // An entry is live when its distance from head is below count.
    always_comb begin
        ptr_t off;
        off        = '0;
        valid      = '0;
        entry_addr = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            off           = PTR_W'(i) - head;
            valid[i]      = (CNT_W'(off) < count);
            entry_addr[i] = entries[i].addr;
        end
    end

    store_buffer_sb_fwd_match u_fwd (
        .valid      (valid),
        .entry_addr (entry_addr),
        .head       (head),
        .lookup     (bus.address),
        .hit        (hit),
        .idx        (hit_idx)
    );

    // Port arbitration: load, then enqueue, then drain.
    always_comb begin
        bus.stall         = bus.mem_write && !bus.mem_read && full;
        bus.empty         = (count == '0);
        bus.dm_read       = bus.mem_read;
        bus.dm_write      = drain;
        bus.dm_address    = '0;
        bus.dm_write_data = '0;
        bus.load_data     = '0;
        if (bus.mem_read) begin
            bus.dm_address = bus.address;
            bus.load_data  = hit ? entries[hit_idx].data : bus.dm_read_data;
        end else if (drain) begin
            bus.dm_address    = entries[head].addr;
            bus.dm_write_data = entries[head].data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq) begin
                tail  <= tail + PTR_W'(1);
                count <= count + CNT_W'(1);
            end
            if (drain) begin
                head  <= head + PTR_W'(1);
                count <= count - CNT_W'(1);
            end
        end
    end

    // Payload storage needs no reset; validity comes from the pointers.
    always_ff @(posedge clk) begin
        if (enq) begin
            entries[tail] <= '{addr: bus.address, data: bus.write_data};
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer with a queue-based reference model.
module tb_store_buffer;
    import store_buffer_pkg::*;

    typedef struct {
        addr_t a;
        data_t d;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic mem_init = 1'b1;
    always #5 clk = ~clk;

    store_buffer_if bus ();

    store_buffer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    data_t dmem [2**ADDR_W];
    data_t ref_mem [2**ADDR_W];
    ent_t  q [$];

    int    n_cmp = 0;
    int    n_bad = 0;
    logic  exp_empty, exp_stall, exp_dm_write, exp_dm_read;
    addr_t exp_addr;
    data_t exp_wdata, exp_load;
    logic  pend_enq, pend_drain;
    addr_t pend_a;
    data_t pend_d;

    function automatic data_t init_val(int i);
        return DATA_W'(32'hA5A5_0000 ^ (i * 32'h9E37));
    endfunction

    // DataMemory model: combinational read, synchronous write.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 2**ADDR_W; i++) dmem[i] <= init_val(i);
        end else if (bus.dm_write) begin
            dmem[bus.dm_address] <= bus.dm_write_data;
        end
    end
    assign bus.dm_read_data = dmem[bus.dm_address];

    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(bus.mem_read && bus.mem_write))
            else $error("FAIL illegal_rw: read and write both high");
        end
    end

    // Drive one cycle of inputs and derive expected outputs from the model.
    task automatic apply(input logic w, input logic r, input addr_t a, input data_t d);
        @(negedge clk);
        bus.mem_write  = w;
        bus.mem_read   = r;
        bus.address    = a;
        bus.write_data = d;
        #1;
        exp_empty    = (q.size() == 0);
        exp_stall    = w && !r && (q.size() == int'(DEPTH));
        pend_enq     = w && !r && (q.size() < int'(DEPTH));
        pend_drain   = !r && !pend_enq && (q.size() > 0);
        pend_a       = a;
        pend_d       = d;
        exp_dm_write = pend_drain;
        exp_dm_read  = r;
        exp_addr     = r ? a : (pend_drain ? q[0].a : '0);
        exp_wdata    = pend_drain ? q[0].d : '0;
        exp_load     = '0;
        if (r) begin
            exp_load = ref_mem[a];
            foreach (q[k]) if (q[k].a == a) exp_load = q[k].d;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (pend_drain) begin
            ref_mem[q[0].a] = q[0].d;
            void'(q.pop_front());
        end else if (pend_enq) begin
            q.push_back('{a: pend_a, d: pend_d});
        end
        pend_enq   = 1'b0;
        pend_drain = 1'b0;
    endtask

    task automatic test_reset();
        bus.mem_write  = 1'b0;
        bus.mem_read   = 1'b0;
        bus.address    = '0;
        bus.write_data = '0;
        for (int i = 0; i < 2**ADDR_W; i++) ref_mem[i] = init_val(i);
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (bus.empty !== 1'b1) begin n_bad++; $display("FAIL reset_empty_in_reset: got %0b exp 1", bus.empty); end
        @(negedge clk);
        mem_init = 1'b0;
        rst_n    = 1'b1;
        for (int c = 0; c < 3; c++) begin
            apply(1'b0, 1'b0, '0, '0);
            n_cmp++; if (bus.empty !== 1'b1) begin n_bad++; $display("FAIL reset_empty: got %0b exp 1", bus.empty); end
            n_cmp++; if (bus.stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %0b exp 0", bus.stall); end
            n_cmp++; if (bus.dm_write !== 1'b0) begin n_bad++; $display("FAIL reset_dm_write: got %0b exp 0", bus.dm_write); end
            n_cmp++; if (bus.dm_read !== 1'b0) begin n_bad++; $display("FAIL reset_dm_read: got %0b exp 0", bus.dm_read); end
            n_cmp++; if (bus.load_data !== '0) begin n_bad++; $display("FAIL reset_load: got %h exp 0", bus.load_data); end
            tick();
        end
    endtask

    task automatic test_store_forward();
        apply(1'b1, 1'b0, 9'h010, 32'hDEADBEEF);
        n_cmp++; if (bus.stall !== 1'b0) begin n_bad++; $display("FAIL fwd_store_stall: got %0b exp 0", bus.stall); end
        n_cmp++; if (bus.dm_write !== 1'b0) begin n_bad++; $display("FAIL fwd_store_dm_write: got %0b exp 0", bus.dm_write); end
        tick();
        apply(1'b0, 1'b1, 9'h010, '0);
        n_cmp++; if (bus.load_data !== 32'hDEADBEEF) begin n_bad++; $display("FAIL fwd_load: got %h exp deadbeef", bus.load_data); end
        n_cmp++; if (bus.dm_write !== 1'b0) begin n_bad++; $display("FAIL fwd_load_dm_write: got %0b exp 0", bus.dm_write); end
        n_cmp++; if (bus.empty !== 1'b0) begin n_bad++; $display("FAIL fwd_empty: got %0b exp 0", bus.empty); end
        tick();
        apply(1'b0, 1'b0, '0, '0);
        n_cmp++; if (bus.dm_write !== 1'b1) begin n_bad++; $display("FAIL fwd_drain_we: got %0b exp 1", bus.dm_write); end
        n_cmp++; if (bus.dm_address !== 9'h010) begin n_bad++; $display("FAIL fwd_drain_addr: got %h exp 010", bus.dm_address); end
        n_cmp++; if (bus.dm_write_data !== 32'hDEADBEEF) begin n_bad++; $display("FAIL fwd_drain_data: got %h exp deadbeef", bus.dm_write_data); end
        tick();
    endtask

    task automatic test_same_addr();
        apply(1'b1, 1'b0, 9'h020, 32'd1); tick();
        apply(1'b1, 1'b0, 9'h020, 32'd2); tick();
        apply(1'b0, 1'b1, 9'h020, '0);
        n_cmp++; if (bus.load_data !== 32'd2) begin n_bad++; $display("FAIL same_load: got %h exp 2", bus.load_data); end
        tick();
        for (int k = 1; k <= 2; k++) begin
            apply(1'b0, 1'b0, '0, '0);
            n_cmp++; if (bus.dm_write !== 1'b1) begin n_bad++; $display("FAIL same_drain_we%0d: got %0b exp 1", k, bus.dm_write); end
            n_cmp++; if (bus.dm_address !== 9'h020) begin n_bad++; $display("FAIL same_drain_addr%0d: got %h exp 020", k, bus.dm_address); end
            n_cmp++; if (bus.dm_write_data !== DATA_W'(k)) begin n_bad++; $display("FAIL same_drain_data%0d: got %h exp %0d", k, bus.dm_write_data, k); end
            tick();
        end
        apply(1'b0, 1'b0, '0, '0);
        n_cmp++; if (dmem[9'h020] !== 32'd2) begin n_bad++; $display("FAIL same_mem: got %h exp 2", dmem[9'h020]); end
        n_cmp++; if (bus.empty !== 1'b1) begin n_bad++; $display("FAIL same_empty: got %0b exp 1", bus.empty); end
        tick();
    endtask

    task automatic test_full();
        for (int k = 1; k <= 4; k++) begin
            apply(1'b1, 1'b0, ADDR_W'(k), DATA_W'(32'h1000 + k));
            n_cmp++; if (bus.stall !== 1'b0) begin n_bad++; $display("FAIL full_fill_stall%0d: got %0b exp 0", k, bus.stall); end
            tick();
        end
        apply(1'b1, 1'b0, 9'h005, 32'h1005);
        n_cmp++; if (bus.stall !== 1'b1) begin n_bad++; $display("FAIL full_stall: got %0b exp 1", bus.stall); end
        n_cmp++; if (bus.dm_write !== 1'b1) begin n_bad++; $display("FAIL full_drain_we: got %0b exp 1", bus.dm_write); end
        n_cmp++; if (bus.dm_address !== 9'h001) begin n_bad++; $display("FAIL full_drain_addr: got %h exp 001", bus.dm_address); end
        tick();
        apply(1'b1, 1'b0, 9'h005, 32'h1005);
        n_cmp++; if (bus.stall !== 1'b0) begin n_bad++; $display("FAIL full_retry_stall: got %0b exp 0", bus.stall); end
        n_cmp++; if (bus.dm_write !== 1'b0) begin n_bad++; $display("FAIL full_retry_we: got %0b exp 0", bus.dm_write); end
        tick();
        for (int k = 0; k < 4; k++) begin
            apply(1'b0, 1'b0, '0, '0);
            n_cmp++; if (bus.dm_write !== 1'b1) begin n_bad++; $display("FAIL full_wrap_we%0d: got %0b exp 1", k, bus.dm_write); end
            n_cmp++; if (bus.dm_address !== ADDR_W'(k + 2)) begin n_bad++; $display("FAIL full_wrap_addr%0d: got %h exp %h", k, bus.dm_address, k + 2); end
            n_cmp++; if (bus.dm_write_data !== DATA_W'(32'h1002 + k)) begin n_bad++; $display("FAIL full_wrap_data%0d: got %h exp %h", k, bus.dm_write_data, 32'h1002 + k); end
            tick();
        end
        apply(1'b0, 1'b0, '0, '0);
        n_cmp++; if (bus.dm_write !== 1'b0) begin n_bad++; $display("FAIL full_done_we: got %0b exp 0", bus.dm_write); end
        n_cmp++; if (bus.empty !== 1'b1) begin n_bad++; $display("FAIL full_done_empty: got %0b exp 1", bus.empty); end
        tick();
    endtask

    task automatic test_load_miss();
        apply(1'b1, 1'b0, 9'h030, 32'h12345678); tick();
        apply(1'b0, 1'b0, '0, '0); tick();
        apply(1'b0, 1'b1, 9'h030, '0);
        n_cmp++; if (bus.empty !== 1'b1) begin n_bad++; $display("FAIL miss_empty: got %0b exp 1", bus.empty); end
        n_cmp++; if (bus.dm_read !== 1'b1) begin n_bad++; $display("FAIL miss_dm_read: got %0b exp 1", bus.dm_read); end
        n_cmp++; if (bus.dm_address !== 9'h030) begin n_bad++; $display("FAIL miss_addr: got %h exp 030", bus.dm_address); end
        n_cmp++; if (bus.load_data !== 32'h12345678) begin n_bad++; $display("FAIL miss_load: got %h exp 12345678", bus.load_data); end
        tick();
        apply(1'b0, 1'b0, 9'h030, '0);
        n_cmp++; if (bus.load_data !== '0) begin n_bad++; $display("FAIL miss_noread_load: got %h exp 0", bus.load_data); end
        n_cmp++; if (bus.dm_read !== 1'b0) begin n_bad++; $display("FAIL miss_noread_dm_read: got %0b exp 0", bus.dm_read); end
        tick();
    endtask

    task automatic test_random();
        int op;
        for (int c = 0; c < 300; c++) begin
            op = int'($urandom_range(0, 9));
            apply(op < 4, (op >= 4) && (op < 7), ADDR_W'($urandom_range(0, 15)), $urandom);
            n_cmp++; if (bus.empty !== exp_empty) begin n_bad++; $display("FAIL rnd_empty c%0d: got %0b exp %0b", c, bus.empty, exp_empty); end
            n_cmp++; if (bus.stall !== exp_stall) begin n_bad++; $display("FAIL rnd_stall c%0d: got %0b exp %0b", c, bus.stall, exp_stall); end
            n_cmp++; if (bus.dm_write !== exp_dm_write) begin n_bad++; $display("FAIL rnd_dm_write c%0d: got %0b exp %0b", c, bus.dm_write, exp_dm_write); end
            n_cmp++; if (bus.dm_read !== exp_dm_read) begin n_bad++; $display("FAIL rnd_dm_read c%0d: got %0b exp %0b", c, bus.dm_read, exp_dm_read); end
            n_cmp++; if (bus.load_data !== exp_load) begin n_bad++; $display("FAIL rnd_load c%0d: got %h exp %h", c, bus.load_data, exp_load); end
            if (exp_dm_write || exp_dm_read) begin
                n_cmp++; if (bus.dm_address !== exp_addr) begin n_bad++; $display("FAIL rnd_addr c%0d: got %h exp %h", c, bus.dm_address, exp_addr); end
            end
            if (exp_dm_write) begin
                n_cmp++; if (bus.dm_write_data !== exp_wdata) begin n_bad++; $display("FAIL rnd_wdata c%0d: got %h exp %h", c, bus.dm_write_data, exp_wdata); end
            end
            tick();
        end
        repeat (DEPTH + 1) begin
            apply(1'b0, 1'b0, '0, '0);
            n_cmp++; if (bus.dm_write !== exp_dm_write) begin n_bad++; $display("FAIL rnd_flush_we: got %0b exp %0b", bus.dm_write, exp_dm_write); end
            tick();
        end
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            n_cmp++; if (dmem[i] !== ref_mem[i]) begin n_bad++; $display("FAIL rnd_mem[%0d]: got %h exp %h", i, dmem[i], ref_mem[i]); end
        end
    endtask

    task automatic test_reset_midcycle();
        for (int k = 0; k < 3; k++) begin
            apply(1'b1, 1'b0, ADDR_W'(9'h040 + k), DATA_W'(32'hC0DE_0000 + k));
            tick();
        end
        @(negedge clk);
        bus.mem_write = 1'b0;
        bus.mem_read  = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        q.delete();
        n_cmp++; if (bus.empty !== 1'b1) begin n_bad++; $display("FAIL rstmid_empty: got %0b exp 1", bus.empty); end
        n_cmp++; if (bus.dm_write !== 1'b0) begin n_bad++; $display("FAIL rstmid_we: got %0b exp 0", bus.dm_write); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            apply(1'b0, 1'b0, '0, '0);
            n_cmp++; if (bus.dm_write !== 1'b0) begin n_bad++; $display("FAIL rstmid_post_we%0d: got %0b exp 0", c, bus.dm_write); end
            n_cmp++; if (bus.empty !== 1'b1) begin n_bad++; $display("FAIL rstmid_post_empty%0d: got %0b exp 1", c, bus.empty); end
            tick();
        end
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            n_cmp++; if (dmem[9'h040 + k] !== ref_mem[9'h040 + k]) begin n_bad++; $display("FAIL rstmid_mem%0d: got %h exp %h", k, dmem[9'h040 + k], ref_mem[9'h040 + k]); end
        end
    endtask

    initial begin
        pend_enq   = 1'b0;
        pend_drain = 1'b0;
        test_reset();
        test_store_forward();
        test_same_addr();
        test_full();
        test_load_miss();
        test_random();
        test_reset_midcycle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
